gemm_tile_scheduler: RTL
========================

# gemm_tile_scheduler

Sequencing controller for one `InnerProduct1DArray` pass over a GEMM tile. On `start` it streams `num_rows` row indices to the operand buffers that feed the array. It tracks each issued row through the buffer-read and array pipeline latency and captures the `NUM` results per row into an output FIFO. The FIFO drains through a valid/ready port. Issue is credit-limited so that no array result is ever dropped, because the array has no stall input.

## Interface

Parameters:
- `NUM`, 4: inner-product units in the array (result lanes per row).
- `OUTPUT_DATA_WIDTH`, 32: width of one lane result.
- `ROW_ADDR_WIDTH`, 8: width of the row index and row count.
- `RD_LATENCY`, 1: cycles from `row_rd_en` until operands are present at the array inputs.
- `PIPE_LATENCY`, 3: array input-to-output latency in cycles.
- `FIFO_DEPTH`, 4: result FIFO entries; must be ≥1. Full throughput requires ≥ `RD_LATENCY+PIPE_LATENCY+1`.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request to begin a tile; sampled only in IDLE.
- `num_rows` in `ROW_ADDR_WIDTH`: row count M, sampled with `start`.
- `busy` out 1: high from the cycle after an accepted `start` until the cycle of `done`.
- `done` out 1: one-cycle pulse at tile completion.
- `row_rd_en` out 1: operand-buffer read strobe.
- `row_addr` out `ROW_ADDR_WIDTH`: row index read this cycle.
- `array_data_in` in `NUM*OUTPUT_DATA_WIDTH`: array `data_out`, with lane j at bits `[j*W +: W]`.
- `out_valid` out 1: the FIFO head is valid.
- `out_ready` in 1: consumer accepts the head.
- `out_data` out `NUM*OUTPUT_DATA_WIDTH`: the result row.
- `out_row` out `ROW_ADDR_WIDTH`: row index tag for `out_data`.
- `stall_cycles` out 32: present only with `GEMM_SCHED_PERF_EN`.

## Operation

- Let L = `RD_LATENCY+PIPE_LATENCY`.
- A valid/tag shift register of length L accompanies each `row_rd_en`.
- The array output is captured into the FIFO only when the tap at stage L is valid.
- inflight = number of valid stages in the shift register.
- credit = `FIFO_DEPTH` − fifo_count − inflight.
- A pop in the same cycle counts: credit is computed with fifo_count after the pop.
- States:
  - IDLE, on `start` with `num_rows`≠0: latch M, go to ISSUE, clear the row counter.
  - IDLE, on `start` with `num_rows`=0: pulse `done` next cycle and stay in IDLE; `busy` stays 0.
  - ISSUE: while credit>0, assert `row_rd_en` with `row_addr`=counter and increment the counter. After issuing row M−1, go to DRAIN in the next cycle.
  - DRAIN: when inflight=0, the FIFO is empty, and no push is pending, pulse `done` and return to IDLE.
- `start` outside IDLE is ignored.
- Rows are issued in order 0..M−1, and results pop in the same order.
- `out_data` and `out_row` are held stable while `out_valid`=1 and `out_ready`=0.
- Push and pop in the same cycle are both legal. The FIFO never overflows, by construction of credit.
- Reset at any time:
  - state returns to IDLE;
  - the FIFO is emptied;
  - the shift register is cleared;
  - in-flight results are discarded.
- Reset values: every output is 0, including `row_addr`, `out_data`, `out_row` and `stall_cycles`.

## Timing

- `start` accepted at edge t means `busy`=1 and the first `row_rd_en` from cycle t+1, if credit>0.
- A row issued in cycle c is captured from `array_data_in` at the end of cycle c+L. It appears at the FIFO head with `out_valid` at c+L+1 at the earliest.
- With `out_ready`=1 and `FIFO_DEPTH` ≥ L+1, there is one row per cycle and no issue bubbles.
- `done` asserts in the cycle after the last pop handshake. `busy` falls in that same cycle.
- The FIFO head is registered. There is no combinational path from `out_ready` to `out_valid` or `out_data`.
- The combinational path from `out_ready` to `row_rd_en` through credit is permitted.

## Configuration

- `GEMM_SCHED_PERF_EN` defined:
  - adds the `stall_cycles` port;
  - `stall_cycles` increments each cycle in ISSUE with credit=0;
  - it clears on an accepted `start` and on reset, saturates at 2^32−1, and is held after `done`.
- `GEMM_SCHED_PERF_EN` undefined: neither the port nor the counter exists. All other behaviour is identical.

## Test plan

- Defaults (L=4), `num_rows`=3, `out_ready`=1, `start` at cycle 0:
  - `row_rd_en` in cycles 1–3 with addr 0, 1, 2;
  - `out_valid` in cycles 6–8 with `out_row` 0, 1, 2 and lane data matching the array model;
  - `done` in cycle 9.
- `num_rows`=0 → `done` in cycle 1, `busy` never 1, no `row_rd_en`.
- `num_rows`=10, `out_ready`=0 → exactly 4 `row_rd_en`, then none. After raising `out_ready`, all 10 rows pop in order 0–9 and `done` fires once. With PERF enabled, `stall_cycles` equals the counted credit-0 ISSUE cycles.
- Randomised `out_ready` (50%), `num_rows`=20 → no lost or duplicated rows, `out_data` stable while stalled, one `done`.
- `start` pulsed while `busy`, `num_rows`=5, with a second `start` and `num_rows`=2 → the second request is ignored and exactly 5 rows are output.
- `rst` low in cycle 3 of a 10-row tile → all outputs 0 asynchronously. A subsequent `num_rows`=2 tile outputs only rows 0 and 1, with no stale results.

Source files
------------

// File: rtl/gemm_tile_scheduler.sv
// gemm_tile_scheduler
//   Sequences one InnerProduct1DArray pass over a GEMM tile. Issues num_rows row reads to the
//   operand buffers, tracks each row through the read + array latency with a valid/tag shift
//   register, and captures each result row into a FIFO that drains over valid/ready. Issue is
//   credit-limited because the array cannot stall: a row is only issued if a FIFO slot is
//   guaranteed for it when it emerges.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   start, num_rows   tile request and row count, sampled in IDLE only
//   busy, done        tile in progress, one-cycle completion pulse
//   row_rd_en         operand-buffer read strobe, row_addr = row index read
//   array_data_in     array result, lane j at [j*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH]
//   out_valid/ready   result FIFO handshake, out_data = result row, out_row = its row index
//   stall_cycles      ISSUE cycles with no credit (only when GEMM_SCHED_PERF_EN is defined)
//
// Optional feature macro: GEMM_SCHED_PERF_EN
module gemm_tile_scheduler #(
    parameter int unsigned NUM               = 4,
    parameter int unsigned OUTPUT_DATA_WIDTH = 32,
    parameter int unsigned ROW_ADDR_WIDTH    = 8,
    parameter int unsigned RD_LATENCY        = 1,
    parameter int unsigned PIPE_LATENCY      = 3,
    parameter int unsigned FIFO_DEPTH        = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [ROW_ADDR_WIDTH-1:0]           num_rows,
    output logic                                busy,
    output logic                                done,
    output logic                                row_rd_en,
    output logic [ROW_ADDR_WIDTH-1:0]           row_addr,
    input  logic [NUM*OUTPUT_DATA_WIDTH-1:0]    array_data_in,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [NUM*OUTPUT_DATA_WIDTH-1:0]    out_data,
`ifdef GEMM_SCHED_PERF_EN
    output logic [31:0]                         stall_cycles,
`endif
    output logic [ROW_ADDR_WIDTH-1:0]           out_row
);

    localparam int unsigned DW = NUM * OUTPUT_DATA_WIDTH;
    localparam int unsigned L  = RD_LATENCY + PIPE_LATENCY;
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [ROW_ADDR_WIDTH-1:0] ROW_ONE  = ROW_ADDR_WIDTH'(1);
    localparam logic [PW-1:0]             PTR_ONE  = PW'(1);
    localparam logic [PW-1:0]             PTR_LAST = PW'(FIFO_DEPTH - 1);

    logic [1:0]                r_state;
    logic [1:0]                w_state_d;
    logic [ROW_ADDR_WIDTH-1:0] r_m;
    logic [ROW_ADDR_WIDTH-1:0] r_cnt;
    logic                      r_done;

    // Stage i valid means the row issued i+1 cycles ago is still in the read/array pipeline.
    logic [L-1:0]              r_vld;
    logic [ROW_ADDR_WIDTH-1:0] r_tag [L];

    logic [DW-1:0]             r_mem     [FIFO_DEPTH];
    logic [ROW_ADDR_WIDTH-1:0] r_mem_tag [FIFO_DEPTH];
    logic [PW-1:0]             r_wptr;
    logic [PW-1:0]             r_rptr;
    logic [CW-1:0]             r_count;

    logic                      w_accept;
    logic                      w_push;
    logic                      w_pop;
    logic [CW-1:0]             w_count_after;
    logic [31:0]               w_inflight;
    logic                      w_credit;
    logic                      w_issue;
    logic                      w_last;
    logic                      w_drained;

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < int'(L); i++) begin
            w_inflight = w_inflight + 32'(r_vld[i]);
        end
    end

    assign w_accept      = (r_state == S_IDLE) && start;
    assign w_push        = r_vld[L-1];
    assign w_pop         = out_valid && out_ready;
    // A same-cycle pop frees its slot immediately, so credit uses the post-pop occupancy.
    assign w_count_after = r_count - CW'(w_pop);
    assign w_credit      = (32'(w_count_after) + w_inflight) < FIFO_DEPTH;
    assign w_issue       = (r_state == S_ISSUE) && w_credit;
    assign w_last        = (r_cnt == (r_m - ROW_ONE));
    assign w_drained     = (r_state == S_DRAIN) && (w_count_after == '0) &&
                           (w_inflight == '0) && !w_push;

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            S_IDLE:  if (start && (num_rows != '0)) w_state_d = S_ISSUE;
            S_ISSUE: if (w_issue && w_last)         w_state_d = S_DRAIN;
            S_DRAIN: if (w_drained)                 w_state_d = S_IDLE;
            default: w_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_m     <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_done  <= (w_accept && (num_rows == '0)) || w_drained;
            if (w_accept) begin
                r_m   <= num_rows;
                r_cnt <= '0;
            end else if (w_issue) begin
                r_cnt <= r_cnt + ROW_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld <= '0;
            for (int i = 0; i < int'(L); i++) r_tag[i] <= '0;
        end else begin
            r_vld[0] <= w_issue;
            r_tag[0] <= r_cnt;
            for (int i = 1; i < int'(L); i++) begin
                r_vld[i] <= r_vld[i-1];
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                r_mem[i]     <= '0;
                r_mem_tag[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr]     <= array_data_in;
                r_mem_tag[r_wptr] <= r_tag[L-1];
                r_wptr            <= (r_wptr == PTR_LAST) ? '0 : r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == PTR_LAST) ? '0 : r_rptr + PTR_ONE;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

`ifdef GEMM_SCHED_PERF_EN
    logic [31:0] r_stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall <= '0;
        end else if (w_accept) begin
            r_stall <= '0;
        end else if ((r_state == S_ISSUE) && !w_credit && (r_stall != '1)) begin
            r_stall <= r_stall + 32'd1;
        end
    end

    assign stall_cycles = r_stall;
`endif

    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign row_rd_en = w_issue;
    assign row_addr  = w_issue ? r_cnt : '0;
    assign out_valid = (r_count != '0);
    assign out_data  = r_mem[r_rptr];
    assign out_row   = r_mem_tag[r_rptr];

endmodule
